// File: rtl/sprite_pkg.sv
// Shared constants and types for the Player 1 sprite fetch path.
// Imported by the animation FSM and the fetch top level.
package sprite_pkg;

  localparam logic [15:0] TRANSPARENT_MASK = 16'hFF43;
  localparam int          SPR_W_DEF        = 32;
  localparam int          SPR_H_DEF        = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    JUMP = 2'd2
  } anim_state_t;

  // Indices 0, 1, 6 and 8-15 carry no visible colour.
  function automatic logic is_transparent(input logic [3:0] idx);
    return TRANSPARENT_MASK[idx];
  endfunction

endpackage

// File: rtl/anim_fsm.sv
// Vsync falling-edge detector plus the idle/run/jump animation sequencer.
// Produces the per-frame latch strobe and the sprite frame number.
module anim_fsm
  import sprite_pkg::*;
#(
  parameter int NUM_RUN     = 4,
  parameter int FRAME_TICKS = 6,
  parameter int FW          = $clog2(NUM_RUN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          moving,
  input  logic          jumping,
  output logic          latch,
  output logic [FW-1:0] frame
);

  localparam int            TW         = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(FRAME_TICKS - 1);
  localparam logic [FW-1:0] RUN_LAST   = FW'(NUM_RUN - 1);
  localparam logic [FW-1:0] JUMP_FRAME = FW'(NUM_RUN);

  anim_state_t   state_reg;
  logic          vs_d_reg;
  logic [TW-1:0] tick_reg;
  logic [FW-1:0] frame_reg;

  // Strobe is high for exactly one cycle however long vs stays low.
  assign latch = vs_d_reg & ~vs;
  assign frame = frame_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_reg  <= 1'b1;
      state_reg <= IDLE;
      tick_reg  <= '0;
      frame_reg <= '0;
    end else begin
      vs_d_reg <= vs;
      if (latch) begin
        if (jumping) begin
          state_reg <= JUMP;
          tick_reg  <= '0;
          frame_reg <= JUMP_FRAME;
        end else if (moving) begin
          state_reg <= RUN;
          if (state_reg == RUN) begin
            // Staying in RUN keeps the cadence going across edges.
            if (tick_reg == TICK_LAST) begin
              tick_reg  <= '0;
              frame_reg <= (frame_reg == RUN_LAST) ? '0 : frame_reg + 1'b1;
            end else begin
              tick_reg <= tick_reg + 1'b1;
            end
          end else begin
            tick_reg  <= '0;
            frame_reg <= '0;
          end
        end else begin
          state_reg <= IDLE;
          tick_reg  <= '0;
          frame_reg <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/player1_sprite_fetch.sv
// Player 1 sprite fetch: hit test, mirrored ROM addressing and a fixed
// 3-cycle pipeline delivering palette index plus opaque flag.
module player1_sprite_fetch
  import sprite_pkg::*;
#(
  parameter int SPR_W       = SPR_W_DEF,
  parameter int SPR_H       = SPR_H_DEF,
  parameter int NUM_RUN     = 4,
  parameter int FRAME_TICKS = 6,
  parameter int ROM_AW      = $clog2((NUM_RUN + 1) * SPR_W * SPR_H)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              vs,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        PlayerX,
  input  logic [9:0]        PlayerY,
  input  logic              moving,
  input  logic              jumping,
  input  logic              facing_left,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        index,
  output logic              pix_valid
);

  localparam int                FW         = $clog2(NUM_RUN + 1);
  localparam logic [10:0]       W11        = 11'(SPR_W);
  localparam logic [10:0]       H11        = 11'(SPR_H);
  localparam logic [ROM_AW-1:0] FRAME_SIZE = ROM_AW'(SPR_W * SPR_H);
  localparam logic [ROM_AW-1:0] ROW_SIZE   = ROM_AW'(SPR_W);
  localparam logic [ROM_AW-1:0] COL_LAST   = ROM_AW'(SPR_W - 1);

  logic              latch;
  logic [FW-1:0]     frame;

  logic [9:0]        px_reg;
  logic [9:0]        py_reg;
  logic              facing_left_reg;

  logic [10:0]       x_ext, y_ext, px_ext, py_ext;
  logic [10:0]       dx, dy;
  logic              hit;
  logic [ROM_AW-1:0] col;
  logic [ROM_AW-1:0] addr_next;

  logic [ROM_AW-1:0] rom_addr_reg;
  logic [1:0]        hit_dly_reg;
  logic [3:0]        index_reg;
  logic              pix_valid_reg;

  anim_fsm #(
    .NUM_RUN    (NUM_RUN),
    .FRAME_TICKS(FRAME_TICKS),
    .FW         (FW)
  ) u_anim_fsm (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .vs     (vs),
    .moving (moving),
    .jumping(jumping),
    .latch  (latch),
    .frame  (frame)
  );

  // Position and facing only move once per video frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      px_reg          <= '0;
      py_reg          <= '0;
      facing_left_reg <= 1'b0;
    end else if (latch) begin
      px_reg          <= PlayerX;
      py_reg          <= PlayerY;
      facing_left_reg <= facing_left;
    end
  end

  // 11-bit compare so px+SPR_W past 1023 never wraps to the left edge.
  always_comb begin
    x_ext     = {1'b0, DrawX};
    y_ext     = {1'b0, DrawY};
    px_ext    = {1'b0, px_reg};
    py_ext    = {1'b0, py_reg};
    hit       = (x_ext >= px_ext) && (x_ext < px_ext + W11) &&
                (y_ext >= py_ext) && (y_ext < py_ext + H11);
    dx        = x_ext - px_ext;
    dy        = y_ext - py_ext;
    col       = facing_left_reg ? ROM_AW'(dx) : COL_LAST - ROM_AW'(dx);
    addr_next = '0;
    if (hit) begin
      addr_next = ROM_AW'(frame) * FRAME_SIZE + ROM_AW'(dy) * ROW_SIZE + col;
    end
  end

  // Stage 1 issues the address; hit rides two stages to meet rom_q.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_reg  <= '0;
      hit_dly_reg   <= '0;
      index_reg     <= '0;
      pix_valid_reg <= 1'b0;
    end else begin
      rom_addr_reg  <= addr_next;
      hit_dly_reg   <= {hit_dly_reg[0], hit};
      index_reg     <= hit_dly_reg[1] ? rom_q : 4'd0;
      pix_valid_reg <= hit_dly_reg[1] & ~is_transparent(rom_q);
    end
  end

  assign rom_addr  = rom_addr_reg;
  assign index     = index_reg;
  assign pix_valid = pix_valid_reg;

endmodule
